// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl
//   Compares two WIDTH-bit operands one nibble per clock, LSB nibble first,
//   through a single cascadable 4-bit comparator stage. The stage output is
//   registered each cycle and fed back as the cascade input for the next,
//   more significant nibble. Results are published on completion and held
//   until the next completion.
//
//   Optional feature: define SERIAL_CMP_SIGNED_EN for a two's complement
//   compare (sign bit of the top nibble of both operands is inverted before
//   entering the stage). Undefined: unsigned compare.
module serial_compare_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             greater,
  output logic             less
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Flag vectors are packed as {eq, gt, lt}.
  localparam logic [2:0] FLAG_EQ = 3'b100;
  localparam logic [2:0] FLAG_GT = 3'b010;
  localparam logic [2:0] FLAG_LT = 3'b001;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       cas_q, cas_d;
  logic [2:0]       res_q, res_d;

  logic [WIDTH-1:0] a_shift, b_shift;
  logic [3:0]       stg_a, stg_b;
  logic [2:0]       stg_res;
  logic             last_nib;
  logic             start_acc;
  logic             run_step;

  // One cascadable nibble comparator. The current nibble is more significant
  // than everything already folded into the cascade, so it decides first.
  function automatic logic [2:0] nib_cmp(input logic [3:0] an,
                                         input logic [3:0] bn,
                                         input logic       c_gt,
                                         input logic       c_lt);
    logic [2:0] r;
    if (an > bn)      r = FLAG_GT;
    else if (an < bn) r = FLAG_LT;
    else if (c_gt)    r = FLAG_GT;
    else if (c_lt)    r = FLAG_LT;
    else              r = FLAG_EQ;
    return r;
  endfunction

  // Select the current nibble of each operand and run it through the stage.
  always_comb begin
    a_shift  = a_q >> {idx_q, 2'b00};
    b_shift  = b_q >> {idx_q, 2'b00};
    stg_a    = a_shift[3:0];
    stg_b    = b_shift[3:0];
    last_nib = (idx_q == LAST_IDX);
`ifdef SERIAL_CMP_SIGNED_EN
    // Flipping the sign bit maps two's complement order onto unsigned order.
    if (last_nib) begin
      stg_a[3] = ~stg_a[3];
      stg_b[3] = ~stg_b[3];
    end
`else
`endif
    stg_res  = nib_cmp(stg_a, stg_b, cas_q[1], cas_q[0]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort takes precedence over finishing the last nibble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (abort)         state_d = S_IDLE;
        else if (last_nib) state_d = S_DONE;
      end
      S_DONE: state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign run_step  = (state_q == S_RUN) && !abort;

  // Datapath next values: capture on accepted start, advance one nibble per
  // RUN cycle, publish the final stage output on the last nibble.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    idx_d = idx_q;
    cas_d = cas_q;
    res_d = res_q;
    if (start_acc) begin
      a_d   = a;
      b_d   = b;
      idx_d = '0;
      cas_d = FLAG_EQ;
    end else if (run_step) begin
      cas_d = stg_res;
      if (last_nib) begin
        res_d = stg_res;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Datapath registers; everything clears on reset, including operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      idx_q <= '0;
      cas_q <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      idx_q <= idx_d;
      cas_q <= cas_d;
      res_q <= res_d;
    end
  end

  // Registered result flags.
  always_comb begin
    equal   = res_q[2];
    greater = res_q[1];
    less    = res_q[0];
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl (WIDTH=16): table of directed compares plus
// hand-written sequences for abort, reset mid-run and continuous start.
module tb_serial_compare_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             equal;
  logic             greater;
  logic             less;

  int n_vec  = 0;
  int n_fail = 0;

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .equal   (equal),
    .greater (greater),
    .less    (less)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic [2:0]       exp;   // {equal, greater, less}
  } vec_t;

  localparam logic [2:0] EQ = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  vec_t vecs[10];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] res();
    return {equal, greater, less};
  endfunction

  // Start a compare and check the full busy/done timeline and the result.
  task automatic run_cmp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic [2:0] exp, input string name);
    a = ta;
    b = tb_v;
    start = 1'b1;
    tick();                     // edge T taken, now in cycle T+1
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check({name, " busy"}, {6'd0, busy, done}, 8'b10);
      tick();
    end
    check({name, " done"}, {6'd0, busy, done}, 8'b01);
    check({name, " result"}, {5'd0, res()}, {5'd0, exp});
    tick();
    check({name, " done_low"}, {6'd0, busy, done}, 8'b00);
    check({name, " held"}, {5'd0, res()}, {5'd0, exp});
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h1234, EQ};
    vecs[1] = '{16'h2000, 16'h1FFF, GT};
    vecs[2] = '{16'h1200, 16'h1201, LT};
`ifdef SERIAL_CMP_SIGNED_EN
    vecs[3] = '{16'h8001, 16'h7FFF, LT};
    vecs[4] = '{16'hFFFF, 16'h0000, LT};
    vecs[5] = '{16'h0000, 16'hFFFF, GT};
`else
    vecs[3] = '{16'h8001, 16'h7FFF, GT};
    vecs[4] = '{16'hFFFF, 16'h0000, GT};
    vecs[5] = '{16'h0000, 16'hFFFF, LT};
`endif
    vecs[6] = '{16'h0000, 16'h0000, EQ};
    vecs[7] = '{16'h1111, 16'h1112, LT};
    vecs[8] = '{16'hF0F0, 16'hF0F1, LT};
    vecs[9] = '{16'hABCD, 16'hABCC, GT};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset: everything stays low.
    for (int i = 0; i < 10; i++) begin
      check("idle_outputs", {3'd0, busy, done, equal, greater, less}, 8'd0);
      tick();
    end

    // Table of directed compares.
    for (int i = 0; i < 10; i++) begin
      run_cmp(vecs[i].va, vecs[i].vb, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Abort at T+2 after an equal result: no done, equal held.
    run_cmp(16'h1234, 16'h1234, EQ, "pre_abort");
    a = 16'h0001;
    b = 16'h0000;
    start = 1'b1;
    tick();                     // T+1
    start = 1'b0;
    tick();                     // T+2
    abort = 1'b1;
    tick();                     // T+3
    abort = 1'b0;
    check("abort_idle", {6'd0, busy, done}, 8'b00);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", {5'd0, done, equal, greater}, 8'b010);
      tick();
    end

    // Abort coinciding with the last nibble: abort wins.
    run_cmp(16'h2000, 16'h1FFF, GT, "pre_abort_last");
    a = 16'h1234;
    b = 16'h1234;
    start = 1'b1;
    tick();                     // T+1
    start = 1'b0;
    tick();                     // T+2
    tick();                     // T+3
    tick();                     // T+4, last nibble
    abort = 1'b1;
    tick();                     // T+5
    abort = 1'b0;
    check("abort_last_state", {6'd0, busy, done}, 8'b00);
    check("abort_last_res", {5'd0, res()}, {5'd0, GT});
    tick();
    check("abort_last_no_done", {7'd0, done}, 8'd0);

    // Abort outside RUN is ignored; a normal compare still completes.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run_cmp(16'h1234, 16'h1234, EQ, "post_idle_abort");

    // Reset at T+2 clears everything.
    a = 16'h0001;
    b = 16'h0000;
    start = 1'b1;
    tick();                     // T+1
    start = 1'b0;
    tick();                     // T+2
    reset = 1'b1;
    tick();                     // T+3
    reset = 1'b0;
    check("reset_midrun", {3'd0, busy, done, equal, greater, less}, 8'd0);
    tick();
    check("reset_stays_idle", {3'd0, busy, done, equal, greater, less}, 8'd0);

    // Continuous start, operands changed mid-run: done every 5 cycles with
    // results from the operands captured at each start.
    a = 16'h2000;
    b = 16'h1FFF;
    start = 1'b1;
    tick();                     // T+1
    check("b2b_busy0", {6'd0, busy, done}, 8'b10);
    tick();                     // T+2
    a = 16'h1200;
    b = 16'h1201;
    tick();
    tick();
    tick();                     // T+5
    check("b2b_done0", {6'd0, busy, done}, 8'b01);
    check("b2b_res0", {5'd0, res()}, {5'd0, GT});
    tick();                     // T+6
    check("b2b_busy1", {6'd0, busy, done}, 8'b10);
    tick();
    a = 16'h5555;
    b = 16'h5555;
    tick();
    tick();
    tick();                     // T+10
    check("b2b_done1", {6'd0, busy, done}, 8'b01);
    check("b2b_res1", {5'd0, res()}, {5'd0, LT});
    tick();                     // T+11
    start = 1'b0;
    a = 16'hFFFF;
    b = 16'h0000;
    tick();
    tick();
    tick();
    tick();                     // T+15
    check("b2b_done2", {6'd0, busy, done}, 8'b01);
    check("b2b_res2", {5'd0, res()}, {5'd0, EQ});
    tick();
    check("b2b_end", {6'd0, busy, done}, 8'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
